// File: rtl/hc595_count_display.sv
// Multi-digit up/down counter with prescaler, rendered as 7-segment glyphs and
// shifted out to a chain of 74HC595s whenever the displayed value changes.
module hc595_count_display #(
    parameter int DIGITS   = 4,
    parameter int MODULUS  = 10,
    parameter int STEP_DIV = 12_000_000,
    parameter int SCLK_DIV = 4
) (
    input  logic                  CLK_i,
    input  logic                  RST_N_i,
    input  logic                  en_i,
    input  logic                  up_i,
    input  logic                  clr_i,
    output logic [4*DIGITS-1:0]   count_o,
    output logic                  busy_o,
    output logic                  SR_DATA_o,
    output logic                  SR_CLK_o,
    output logic                  SR_LATCH_o
);

    localparam int PRE_W      = $clog2(STEP_DIV);
    localparam int FRAME_BITS = 8 * DIGITS;
    localparam int BIT_W      = $clog2(FRAME_BITS);
    localparam int TMR_W      = (SCLK_DIV > 1) ? $clog2(SCLK_DIV) : 1;

    localparam logic [PRE_W-1:0] PRE_LAST = PRE_W'(STEP_DIV - 1);
    localparam logic [3:0]       DIG_LAST = 4'(MODULUS - 1);
    localparam logic [TMR_W-1:0] TMR_LAST = TMR_W'(SCLK_DIV - 1);
    localparam logic [BIT_W-1:0] BIT_LAST = BIT_W'(FRAME_BITS - 1);

    typedef enum logic [1:0] {IDLE, SHIFT_LO, SHIFT_HI, LATCH} state_t;

    state_t                 state_reg, state_next;
    logic [PRE_W-1:0]       pre_reg, pre_next;
    logic [4*DIGITS-1:0]    count_reg, count_next, digits_stepped;
    logic                   pend_reg, pend_next;
    logic                   armed_reg;
    logic [TMR_W-1:0]       tmr_reg, tmr_next;
    logic [BIT_W-1:0]       bit_reg, bit_next;
    logic [FRAME_BITS-1:0]  sr_reg, sr_next, frame_word;
    logic                   busy_reg, data_reg, sclk_reg, latch_reg;
    logic                   step, start;
    logic [DIGITS-1:0]      carry;

    function automatic logic [7:0] glyph(input logic [3:0] v);
        case (v)
            4'h0: return 8'h3F;  4'h1: return 8'h06;
            4'h2: return 8'h5B;  4'h3: return 8'h4F;
            4'h4: return 8'h66;  4'h5: return 8'h6D;
            4'h6: return 8'h7D;  4'h7: return 8'h07;
            4'h8: return 8'h7F;  4'h9: return 8'h6F;
            4'hA: return 8'h77;  4'hB: return 8'h7C;
            4'hC: return 8'h39;  4'hD: return 8'h5E;
            4'hE: return 8'h79;  default: return 8'h71;
        endcase
    endfunction

    assign step     = en_i && (pre_reg == PRE_LAST);
    assign carry[0] = step;

    // Ripple carry/borrow: a digit moves only when every lower digit wraps.
    generate
        for (genvar gi = 0; gi < DIGITS; gi++) begin : g_digit
            logic [3:0] d;
            logic       at_edge;
            assign d       = count_reg[4*gi +: 4];
            assign at_edge = up_i ? (d == DIG_LAST) : (d == 4'd0);
            assign digits_stepped[4*gi +: 4] =
                !carry[gi] ? d :
                up_i       ? (at_edge ? 4'd0 : d + 4'd1) :
                             (at_edge ? DIG_LAST : d - 4'd1);
            assign frame_word[8*gi +: 8] = glyph(d);
            if (gi < DIGITS - 1) begin : g_carry
                assign carry[gi+1] = carry[gi] & at_edge;
            end
        end
    endgenerate

    always_comb begin
        pre_next = pre_reg;
        if (clr_i)
            pre_next = '0;
        else if (en_i)
            pre_next = step ? '0 : pre_reg + 1'b1;
    end

    assign count_next = clr_i ? '0 : digits_stepped;

    always_comb begin
        state_next = state_reg;
        tmr_next   = tmr_reg;
        bit_next   = bit_reg;
        sr_next    = sr_reg;
        start      = 1'b0;
        case (state_reg)
            IDLE: begin
                if (pend_reg && armed_reg) begin
                    state_next = SHIFT_LO;
                    tmr_next   = '0;
                    bit_next   = '0;
                    sr_next    = frame_word;
                    start      = 1'b1;
                end
            end
            SHIFT_LO: begin
                if (tmr_reg == TMR_LAST) begin
                    state_next = SHIFT_HI;
                    tmr_next   = '0;
                end else begin
                    tmr_next = tmr_reg + 1'b1;
                end
            end
            SHIFT_HI: begin
                if (tmr_reg == TMR_LAST) begin
                    tmr_next = '0;
                    if (bit_reg == BIT_LAST) begin
                        state_next = LATCH;
                    end else begin
                        state_next = SHIFT_LO;
                        bit_next   = bit_reg + 1'b1;
                        sr_next    = {sr_reg[FRAME_BITS-2:0], 1'b0};
                    end
                end else begin
                    tmr_next = tmr_reg + 1'b1;
                end
            end
            LATCH: begin
                if (tmr_reg == TMR_LAST) begin
                    state_next = IDLE;
                    tmr_next   = '0;
                end else begin
                    tmr_next = tmr_reg + 1'b1;
                end
            end
            default: state_next = IDLE;
        endcase
    end

    // A change landing on the snapshot edge must still queue a follow-up frame.
    assign pend_next = (count_next != count_reg) | (pend_reg & ~start);

    always_ff @(posedge CLK_i or negedge RST_N_i) begin
        if (!RST_N_i) begin
            state_reg <= IDLE;
            pre_reg   <= '0;
            count_reg <= '0;
            pend_reg  <= 1'b1;
            armed_reg <= 1'b0;
            tmr_reg   <= '0;
            bit_reg   <= '0;
            sr_reg    <= '0;
            busy_reg  <= 1'b0;
            data_reg  <= 1'b0;
            sclk_reg  <= 1'b0;
            latch_reg <= 1'b0;
        end else begin
            state_reg <= state_next;
            pre_reg   <= pre_next;
            count_reg <= count_next;
            pend_reg  <= pend_next;
            armed_reg <= 1'b1;
            tmr_reg   <= tmr_next;
            bit_reg   <= bit_next;
            sr_reg    <= sr_next;
            busy_reg  <= (state_next != IDLE);
            data_reg  <= ((state_next == SHIFT_LO) || (state_next == SHIFT_HI)) ?
                         sr_next[FRAME_BITS-1] : 1'b0;
            sclk_reg  <= (state_next == SHIFT_HI);
            latch_reg <= (state_next == LATCH);
        end
    end

    assign count_o    = count_reg;
    assign busy_o     = busy_reg;
    assign SR_DATA_o  = data_reg;
    assign SR_CLK_o   = sclk_reg;
    assign SR_LATCH_o = latch_reg;

endmodule
